// File: rtl/pkt_ff_rd_ctrl_if.sv
// pkt_ff_rd_ctrl_if: read-side bus of the packet FIFO read controller.
interface pkt_ff_rd_ctrl_if #(parameter int PTR_W = 8);
    logic             rd_en, pkt_start, pkt_commit, pkt_abort;
    logic [PTR_W:0]   wptr_gry_sync;
    logic [PTR_W-1:0] rd_addr;
    logic [PTR_W:0]   rptr_gry, cmt_rptr_gry, occ;
    logic             rd_ack, empty, aempty, seq_err, rd_err;
    modport master (
        output rd_en, pkt_start, pkt_commit, pkt_abort, wptr_gry_sync,
        input  rd_addr, rptr_gry, cmt_rptr_gry, occ, rd_ack, empty, aempty, seq_err, rd_err
    );
    modport slave (
        input  rd_en, pkt_start, pkt_commit, pkt_abort, wptr_gry_sync,
        output rd_addr, rptr_gry, cmt_rptr_gry, occ, rd_ack, empty, aempty, seq_err, rd_err
    );
endinterface

// File: rtl/pkt_ff_rd_ctrl.sv
// pkt_ff_rd_ctrl: FIFO read pointer control with packet rewind (abort) and commit.
module pkt_ff_rd_ctrl #(
    parameter int PTR_W     = 8,
    parameter int AEMPTY_TH = 4
) (
    input logic clk,
    input logic rst,
    pkt_ff_rd_ctrl_if.slave bus
);
    typedef enum logic {IDLE, IN_PKT} state_t;
    state_t         state_q, state_d;
    logic [PTR_W:0] rbin_q, rbin_d, mbin_q, mbin_d, wbin, rinc, rptr_gry_q, cmt_rptr_gry_q;
    logic           rd_ack, seq_err;
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= PTR_W; i++) wbin[i] = ^(bus.wptr_gry_sync >> i);
    end
    assign bus.occ          = wbin - rbin_q;
    assign bus.empty        = bus.occ == '0;
    assign bus.aempty       = bus.occ <= (PTR_W+1)'(AEMPTY_TH);
    assign rd_ack           = bus.rd_en & ~bus.empty & ~bus.pkt_abort;
    assign bus.rd_ack       = rd_ack;
    assign bus.rd_err       = bus.rd_en & bus.empty;
    assign bus.seq_err      = seq_err;
    assign bus.rd_addr      = rbin_q[PTR_W-1:0];
    assign bus.rptr_gry     = rptr_gry_q;
    assign bus.cmt_rptr_gry = cmt_rptr_gry_q;
    assign rinc             = rbin_q + {{PTR_W{1'b0}}, rd_ack};
    // In IDLE mbin equals rbin, so holding it on pkt_start marks the pre-read pointer.
    always_comb begin
        state_d = state_q;
        rbin_d  = rinc;
        mbin_d  = mbin_q;
        seq_err = 1'b0;
        if (state_q == IDLE) begin
            seq_err = bus.pkt_commit | bus.pkt_abort;
            state_d = bus.pkt_start ? IN_PKT : IDLE;
            mbin_d  = bus.pkt_start ? mbin_q : rinc;
        end else begin
            seq_err = bus.pkt_start | (bus.pkt_commit & bus.pkt_abort);
            if (bus.pkt_abort) begin
                state_d = IDLE;
                rbin_d  = mbin_q;
            end else if (bus.pkt_commit) begin
                state_d = IDLE;
                mbin_d  = rinc;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rbin_q         <= '0;
            mbin_q         <= '0;
            rptr_gry_q     <= '0;
            cmt_rptr_gry_q <= '0;
        end else begin
            state_q        <= state_d;
            rbin_q         <= rbin_d;
            mbin_q         <= mbin_d;
            rptr_gry_q     <= rbin_d ^ (rbin_d >> 1);
            cmt_rptr_gry_q <= mbin_d ^ (mbin_d >> 1);
        end
    end
endmodule

// File: tb/tb_pkt_ff_rd_ctrl.sv
// tb_pkt_ff_rd_ctrl: directed bench with a pointer scoreboard for pkt_ff_rd_ctrl.
module tb_pkt_ff_rd_ctrl;
    localparam int PW = 4;
    localparam int TH = 4;
    typedef struct {logic [PW-1:0] addr; logic [PW:0] rg, cg;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    pkt_ff_rd_ctrl_if #(.PTR_W(PW)) bus ();
    pkt_ff_rd_ctrl #(.PTR_W(PW), .AEMPTY_TH(TH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    exp_t sbq[$];
    int ntest = 0, nfail = 0;
    int r_m = 0, m_m = 0, w_m = 0, nack = 0, nerr = 0;
    bit pk_m = 0;
    function automatic logic [PW:0] g(int v);
        logic [PW:0] b;
        b = (PW+1)'(v);
        return b ^ (b >> 1);
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic setw(int v);
        w_m = v & 31;
        bus.wptr_gry_sync = g(v);
    endtask
    task automatic cyc(bit rd, bit st, bit cm, bit ab);
        int occ_e, r_old, m_old;
        bit emp, ack, se;
        logic [PW:0] rg_old, cg_old;
        exp_t e;
        bus.rd_en = rd; bus.pkt_start = st; bus.pkt_commit = cm; bus.pkt_abort = ab;
        #2;
        occ_e = (w_m - r_m) & 31;
        emp = occ_e == 0;
        ack = rd & !emp & !ab;
        se = pk_m ? (st | (cm & ab)) : (cm | ab);
        chk("occ", bus.occ, occ_e);
        chk("empty", bus.empty, emp);
        chk("aempty", bus.aempty, occ_e <= TH);
        chk("rd_ack", bus.rd_ack, ack);
        chk("rd_err", bus.rd_err, rd & emp);
        chk("seq_err", bus.seq_err, se);
        nack += int'(bus.rd_ack === 1'b1);
        nerr += int'(bus.rd_err === 1'b1);
        r_old = r_m; m_old = m_m;
        rg_old = bus.rptr_gry; cg_old = bus.cmt_rptr_gry;
        if (!pk_m) begin
            r_m = (r_m + int'(ack)) & 31;
            if (st) pk_m = 1; else m_m = r_m;
        end else if (ab) begin
            r_m = m_m; pk_m = 0;
        end else begin
            r_m = (r_m + int'(ack)) & 31;
            if (cm) begin m_m = r_m; pk_m = 0; end
        end
        sbq.push_back('{PW'(r_m), g(r_m), g(m_m)});
        @(posedge clk); #1;
        bus.rd_en = 0; bus.pkt_start = 0; bus.pkt_commit = 0; bus.pkt_abort = 0;
        e = sbq.pop_front();
        chk("rd_addr", bus.rd_addr, e.addr);
        chk("rptr_gry", bus.rptr_gry, e.rg);
        chk("cmt_rptr_gry", bus.cmt_rptr_gry, e.cg);
        if (r_m == ((r_old + 1) & 31)) chk("rptr_1bit", $countones(bus.rptr_gry ^ rg_old), 1);
        if (m_m == ((m_old + 1) & 31)) chk("cmt_1bit", $countones(bus.cmt_rptr_gry ^ cg_old), 1);
    endtask
    task automatic do_reset(bit junk);
        rst = 1;
        bus.rd_en = junk; bus.pkt_start = junk; bus.pkt_commit = 0; bus.pkt_abort = junk;
        @(posedge clk); #1;
        rst = 0;
        bus.rd_en = 0; bus.pkt_start = 0; bus.pkt_commit = 0; bus.pkt_abort = 0;
        r_m = 0; m_m = 0; pk_m = 0;
        sbq.delete();
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_rptr", bus.rptr_gry, 0);
        chk("rst_cmt", bus.cmt_rptr_gry, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        bus.rd_en = 0; bus.pkt_start = 0; bus.pkt_commit = 0; bus.pkt_abort = 0;
        setw(0);
        @(posedge clk);
        do_reset(0);
        #2;
        chk("rst_occ", bus.occ, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_aempty", bus.aempty, 1);
        chk("rst_rd_ack", bus.rd_ack, 0);
        chk("rst_seq_err", bus.seq_err, 0);
        @(posedge clk); #1;
        // fill then drain
        setw(10);
        nack = 0; nerr = 0;
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
        chk("drain_acks", nack, 10);
        chk("drain_errs", nerr, 2);
        chk("drain_cmt", bus.cmt_rptr_gry, g(10));
        // abort rewinds to packet start
        do_reset(0);
        setw(3);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        setw(12);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0);
            chk("abort_cmt_hold", bus.cmt_rptr_gry, g(3));
        end
        cyc(1, 0, 0, 1);
        chk("abort_rd_addr", bus.rd_addr, 3);
        chk("abort_cmt", bus.cmt_rptr_gry, g(3));
        #1 chk("abort_occ", bus.occ, 9);
        // commit with same-cycle read
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("commit_rd_addr", bus.rd_addr, 7);
        chk("commit_cmt", bus.cmt_rptr_gry, g(7));
        // commit in IDLE is illegal
        cyc(0, 0, 1, 0);
        // illegal start in packet, then commit plus abort together
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("seqerr_abort_addr", bus.rd_addr, 7);
        // start with abort in IDLE: start honoured
        cyc(1, 1, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("start_abort_addr", bus.rd_addr, 7);
        // packet spanning pointer wrap
        do_reset(0);
        setw(30);
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0);
        setw(3);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk("wrap_rptr", bus.rptr_gry, g(2));
        cyc(0, 0, 0, 1);
        chk("wrap_rd_addr", bus.rd_addr, 14);
        chk("wrap_rptr_back", bus.rptr_gry, g(30));
        chk("wrap_cmt", bus.cmt_rptr_gry, g(30));
        // reset mid-packet discards the open packet
        do_reset(0);
        setw(12);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk("mid_rd_addr", bus.rd_addr, 9);
        chk("mid_cmt", bus.cmt_rptr_gry, g(5));
        do_reset(1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
